// File: rtl/fu_result_merge.sv
// Merges an unbuffered simple-FU result stream with a FIFO-buffered complex-FU stream into one output register.
// Define FU_MERGE_STARVE_GUARD_EN to compile in the starvation counter that forces a FIFO grant after STARVE_LIMIT losses.
module fu_result_merge #(
    parameter int PKT_W        = 64,
    parameter int CFIFO_DEPTH  = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             simple_valid_i,
    input  logic [PKT_W-1:0] simple_pkt_i,
    output logic             simple_ready_o,
    input  logic             complex_valid_i,
    input  logic [PKT_W-1:0] complex_pkt_i,
    output logic             complex_ready_o,
    output logic             out_valid_o,
    output logic [PKT_W-1:0] out_pkt_o,
    input  logic             out_ready_i
);

    localparam int PTR_W = $clog2(CFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CFIFO_DEPTH);

    logic [PKT_W-1:0] r_mem [CFIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_load_en;
    logic w_fifo_ne;
    logic w_force_fifo;
    logic w_grant_fifo;
    logic w_grant_simple;
    logic w_push;
    logic w_pop;

    assign w_load_en = !out_valid_o || out_ready_i;
    assign w_fifo_ne = (r_count != {CNT_W{1'b0}});

`ifdef FU_MERGE_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] r_starve_cnt;

    assign w_force_fifo = (r_starve_cnt == STARVE_MAX);

    // Count consecutive losses of a waiting FIFO head; any pop or empty FIFO clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= {STARVE_W{1'b0}};
        end else if (flush || w_pop || !w_fifo_ne) begin
            r_starve_cnt <= {STARVE_W{1'b0}};
        end else if (w_load_en && w_grant_simple && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end
`else
    assign w_force_fifo = 1'b0;
`endif

    assign w_grant_fifo   = w_load_en && w_fifo_ne && (!simple_valid_i || w_force_fifo);
    assign w_grant_simple = w_load_en && simple_valid_i && !w_grant_fifo;

    // Ready outputs are combinational but forced low during flush and while reset is held.
    assign simple_ready_o  = w_grant_simple && !flush && !reset;
    assign complex_ready_o = (r_count < DEPTH_C) && !flush && !reset;

    assign w_push = complex_valid_i && complex_ready_o;
    assign w_pop  = w_grant_fifo && !flush;

    // FIFO storage has no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= complex_pkt_i;
        end
    end

    // FIFO bookkeeping; pointer arithmetic wraps because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_wptr  <= w_push ? (r_wptr + PTR_W'(1)) : r_wptr;
            r_rptr  <= w_pop  ? (r_rptr + PTR_W'(1)) : r_rptr;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Single output stage: loads the granted packet, holds under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_o <= 1'b0;
            out_pkt_o   <= {PKT_W{1'b0}};
        end else if (flush) begin
            out_valid_o <= 1'b0;
            out_pkt_o   <= out_pkt_o;
        end else if (w_load_en) begin
            if (w_grant_fifo) begin
                out_valid_o <= 1'b1;
                out_pkt_o   <= r_mem[r_rptr];
            end else if (w_grant_simple) begin
                out_valid_o <= 1'b1;
                out_pkt_o   <= simple_pkt_i;
            end else begin
                out_valid_o <= 1'b0;
                out_pkt_o   <= out_pkt_o;
            end
        end else begin
            out_valid_o <= out_valid_o;
            out_pkt_o   <= out_pkt_o;
        end
    end

endmodule

// File: tb/tb_fu_result_merge.sv
// Directed self-checking bench for fu_result_merge; starvation expectations follow FU_MERGE_STARVE_GUARD_EN.
module tb_fu_result_merge;

    localparam int PKT_W = 64;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             simple_valid_i;
    logic [PKT_W-1:0] simple_pkt_i;
    logic             simple_ready_o;
    logic             complex_valid_i;
    logic [PKT_W-1:0] complex_pkt_i;
    logic             complex_ready_o;
    logic             out_valid_o;
    logic [PKT_W-1:0] out_pkt_o;
    logic             out_ready_i;

    int n_checks;
    int n_fail;

    fu_result_merge #(
        .PKT_W       (PKT_W),
        .CFIFO_DEPTH (4),
        .STARVE_LIMIT(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .simple_valid_i (simple_valid_i),
        .simple_pkt_i   (simple_pkt_i),
        .simple_ready_o (simple_ready_o),
        .complex_valid_i(complex_valid_i),
        .complex_pkt_i  (complex_pkt_i),
        .complex_ready_o(complex_ready_o),
        .out_valid_o    (out_valid_o),
        .out_pkt_o      (out_pkt_o),
        .out_ready_i    (out_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        flush           = 1'b0;
        simple_valid_i  = 1'b0;
        simple_pkt_i    = 64'h0;
        complex_valid_i = 1'b0;
        complex_pkt_i   = 64'h0;
        out_ready_i     = 1'b0;

        // Reset asserted between edges must act immediately.
        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'h0);
        check("rst_out_pkt", out_pkt_o, 64'h0);
        check("rst_simple_ready", 64'(simple_ready_o), 64'h0);
        check("rst_complex_ready", 64'(complex_ready_o), 64'h0);
        check("rst_count", 64'(dut.r_count), 64'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Simple only: one-cycle latency.
        out_ready_i    = 1'b1;
        simple_valid_i = 1'b1;
        simple_pkt_i   = 64'hA5;
        #1;
        check("simple_ready", 64'(simple_ready_o), 64'h1);
        tick();
        simple_valid_i = 1'b0;
        check("simple_out_valid", 64'(out_valid_o), 64'h1);
        check("simple_out_pkt", out_pkt_o, 64'hA5);
        tick();
        check("simple_drain", 64'(out_valid_o), 64'h0);

        // Complex fill with output stalled.
        out_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            complex_valid_i = 1'b1;
            complex_pkt_i   = 64'(i);
            #1;
            check("fill_complex_ready", 64'(complex_ready_o), 64'h1);
            tick();
        end
        complex_valid_i = 1'b0;
        #1;
        check("fill_out_valid", 64'(out_valid_o), 64'h1);
        check("fill_out_pkt", out_pkt_o, 64'h1);
        check("fill_full", 64'(complex_ready_o), 64'h0);
        check("fill_count", 64'(dut.r_count), 64'h4);
        out_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            check("fill_order_valid", 64'(out_valid_o), 64'h1);
            check("fill_order_pkt", out_pkt_o, 64'(i));
            tick();
        end
        check("fill_empty", 64'(out_valid_o), 64'h0);

        // Starvation: FIFO head 0x11 against continuous simple traffic.
        complex_valid_i = 1'b1;
        complex_pkt_i   = 64'h11;
        tick();
        complex_valid_i = 1'b0;
        simple_valid_i  = 1'b1;
`ifdef FU_MERGE_STARVE_GUARD_EN
        for (int k = 0; k < 5; k++) begin
            simple_pkt_i = 64'h50 + 64'(k);
            #1;
            check("starve_simple_ready", 64'(simple_ready_o), (k < 4) ? 64'h1 : 64'h0);
            tick();
            check("starve_out_pkt", out_pkt_o, (k < 4) ? (64'h50 + 64'(k)) : 64'h11);
        end
        simple_valid_i = 1'b0;
        check("starve_fifo_empty", 64'(dut.r_count), 64'h0);
        tick();
`else
        for (int k = 0; k < 6; k++) begin
            simple_pkt_i = 64'h50 + 64'(k);
            #1;
            check("nostarve_simple_ready", 64'(simple_ready_o), 64'h1);
            tick();
            check("nostarve_out_pkt", out_pkt_o, 64'h50 + 64'(k));
        end
        simple_valid_i = 1'b0;
        check("nostarve_fifo_held", 64'(dut.r_count), 64'h1);
        tick();
        check("nostarve_late_pkt", out_pkt_o, 64'h11);
        tick();
`endif
        tick();
        check("starve_idle", 64'(out_valid_o), 64'h0);

        // Backpressure holds the output register.
        out_ready_i    = 1'b1;
        simple_valid_i = 1'b1;
        simple_pkt_i   = 64'h22;
        tick();
        out_ready_i  = 1'b0;
        simple_pkt_i = 64'h33;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_simple_ready", 64'(simple_ready_o), 64'h0);
            tick();
            check("bp_out_valid", 64'(out_valid_o), 64'h1);
            check("bp_out_pkt", out_pkt_o, 64'h22);
        end
        out_ready_i = 1'b1;
        tick();
        simple_valid_i = 1'b0;
        check("bp_release_pkt", out_pkt_o, 64'h33);
        tick();
        check("bp_release_idle", 64'(out_valid_o), 64'h0);

        // Flush beats a simultaneous simple grant and clears the FIFO.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            complex_valid_i = 1'b1;
            complex_pkt_i   = 64'h61 + 64'(i);
            tick();
        end
        complex_valid_i = 1'b0;
        check("flush_pre_count", 64'(dut.r_count), 64'h3);
        check("flush_pre_valid", 64'(out_valid_o), 64'h1);
        flush          = 1'b1;
        simple_valid_i = 1'b1;
        simple_pkt_i   = 64'h77;
        out_ready_i    = 1'b1;
        #1;
        check("flush_simple_ready", 64'(simple_ready_o), 64'h0);
        check("flush_complex_ready", 64'(complex_ready_o), 64'h0);
        tick();
        flush          = 1'b0;
        simple_valid_i = 1'b0;
        check("flush_count", 64'(dut.r_count), 64'h0);
        check("flush_out_valid", 64'(out_valid_o), 64'h0);
        tick();
        check("flush_no_accept", 64'(out_valid_o), 64'h0);

        // Asynchronous reset mid-cycle with buffered data.
        out_ready_i = 1'b0;
        complex_valid_i = 1'b1;
        complex_pkt_i   = 64'h81;
        tick();
        complex_pkt_i   = 64'h82;
        tick();
        complex_valid_i = 1'b0;
        check("arst_pre_valid", 64'(out_valid_o), 64'h1);
        check("arst_pre_count", 64'(dut.r_count), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid_o), 64'h0);
        check("arst_out_pkt", out_pkt_o, 64'h0);
        check("arst_ready", 64'(complex_ready_o), 64'h0);
        tick();
        reset = 1'b0;
        check("arst_count", 64'(dut.r_count), 64'h0);
        out_ready_i    = 1'b1;
        simple_valid_i = 1'b1;
        simple_pkt_i   = 64'h99;
        tick();
        simple_valid_i = 1'b0;
        check("arst_resume_pkt", out_pkt_o, 64'h99);
        check("arst_resume_valid", 64'(out_valid_o), 64'h1);
        tick();
        check("arst_resume_idle", 64'(out_valid_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_result_merge.md
FU_RESULT_MERGE -- requirements
Module: fu_result_merge

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  PKT_W  64  opaque result-packet payload width
  CFIFO_DEPTH  4  complex-path buffer entries (power of 2, >=2)
  STARVE_LIMIT  4  consecutive complex-path losses before forced grant
REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  flush  in  1  synchronous pipeline flush
  simple_valid_i  in  1  simple-FU result valid
  simple_pkt_i  in  PKT_W  simple-FU result
  simple_ready_o  out  1  simple result accepted this cycle
  complex_valid_i  in  1  complex-FU result valid
  complex_pkt_i  in  PKT_W  complex-FU result
  complex_ready_o  out  1  complex FIFO can accept
  out_valid_o  out  1  merged result valid
  out_pkt_o  out  PKT_W  merged result
  out_ready_i  in  1  writeback consumes result

Function
REQ-003 Every input transfer SHALL complete only on a cycle with valid and ready both high.
REQ-004 The output SHALL be a single register stage. load_en = !out_valid_o || out_ready_i.
REQ-005 Complex results SHALL enter a CFIFO_DEPTH FIFO. complex_ready_o = (count < CFIFO_DEPTH) && !flush. A push on a full FIFO SHALL NOT occur, including when a pop happens in the same cycle.
REQ-006 Simple results SHALL be unbuffered. simple_ready_o = load_en && grant_simple && !flush.
REQ-007 Arbitration SHALL occur only when load_en is high:
  - simple_valid_i only: grant simple.
  - FIFO non-empty only: grant FIFO head.
  - both present: grant FIFO head iff starve_cnt == STARVE_LIMIT, otherwise grant simple.
  - neither present: out_valid_o <= 0.
REQ-008 Granted packet SHALL appear on out_pkt_o with out_valid_o=1 the cycle after the grant.
  - Simple-path latency = 1 cycle.
  - Complex-path latency with empty FIFO and free output = 2 cycles (push, then pop).
REQ-009 Whenever out_valid_o=1 and out_ready_i=0, out_valid_o and out_pkt_o SHALL hold unchanged.
REQ-010 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL update as follows:
  - increment on a cycle with load_en, FIFO non-empty and simple granted;
  - clear on a FIFO pop or when the FIFO is empty;
  - saturate at STARVE_LIMIT.
REQ-011 FIFO count SHALL be updated as count + push - pop in the same cycle. Read and write pointers SHALL wrap modulo CFIFO_DEPTH.
REQ-012 Output ordering: complex results SHALL leave in arrival order. Packets SHALL NOT be dropped or duplicated except by flush or reset.
REQ-013 flush=1 SHALL do the following at the next edge:
  - clear the FIFO, starve_cnt and out_valid_o;
  - accept no input that cycle (both ready outputs low);
  - take priority over every simultaneous push, pop or grant.

Reset
REQ-014 Asserting reset SHALL immediately force:
  - out_valid_o=0 and out_pkt_o=0;
  - FIFO count and read/write pointers to 0, starve_cnt=0.
REQ-015 While reset is high, both ready outputs SHALL be 0. Reset asserted mid-transfer SHALL discard all buffered packets.
REQ-016 Operation SHALL resume on the first rising clk edge after reset deasserts.

Configuration
REQ-017 Macro FU_MERGE_STARVE_GUARD_EN controls the starvation guard:
  - Defined: starve_cnt and the forced grant of REQ-007/REQ-010 are compiled in.
  - Undefined: starve_cnt is absent and simple strictly wins every tie. All other requirements are unchanged.

Verification
REQ-018 Bench SHALL cover these directed scenarios:
  - Simple only: simple pkt 0xA5 at cycle 1, out_ready_i=1 -> out_pkt_o=0xA5, out_valid_o=1 at cycle 2.
  - Complex fill: 5 back-to-back complex pkts 1..5 with out_ready_i=0 and output empty -> pkt 1 is loaded into the output register, FIFO holds 2..5, complex_ready_o=0; releasing out_ready_i delivers 1..5 in order.
  - Starvation (macro defined): FIFO holds 0x11 with continuous simple valid -> 4 simple grants, then 0x11 is granted on the 5th arbitration cycle. With the macro undefined, 0x11 is never granted while simple stays valid.
  - Backpressure: out_valid_o=1 holding 0x22 with out_ready_i=0 for 3 cycles -> out_pkt_o stays 0x22 and simple_ready_o=0 for those cycles.
  - Flush: FIFO holds 3 entries, output valid, flush together with a simple valid -> next cycle count=0, out_valid_o=0, and the simple pkt is not accepted.
  - Async reset: reset asserted mid-cycle with FIFO non-empty -> out_valid_o=0 before the next edge, FIFO empty after deassertion.
